wb_bus_arbiter: RTL and testbench

//  Shares one Wishbone classic slave port between the IF fetch master (M0) and
//  the MEM-stage load/store master (M1). Arbitrates at transfer boundaries,

---
 rtl/wb_bus_arbiter.sv | 136 +++++++++++++
 tb/tb_wb_bus_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_bus_arbiter.sv
// rtl/wb_bus_arbiter.sv - two-master Wishbone classic arbiter with transfer-locked grant and bus timeout
module wb_bus_arbiter #(
   parameter int unsigned ARB_MODE = 0,
   parameter int unsigned TIMEOUT  = 255,
   parameter int unsigned TO_W     = 8
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        m0_cyc_i,
   input  logic        m0_stb_i,
   input  logic        m0_we_i,
   input  logic [31:0] m0_addr_i,
   input  logic [31:0] m0_dat_i,
   input  logic [3:0]  m0_sel_i,
   output logic        m0_ack_o,
   output logic        m0_err_o,
   output logic [31:0] m0_dat_o,
   input  logic        m1_cyc_i,
   input  logic        m1_stb_i,
   input  logic        m1_we_i,
   input  logic [31:0] m1_addr_i,
   input  logic [31:0] m1_dat_i,
   input  logic [3:0]  m1_sel_i,
   output logic        m1_ack_o,
   output logic        m1_err_o,
   output logic [31:0] m1_dat_o,
   output logic        s_cyc_o,
   output logic        s_stb_o,
   output logic        s_we_o,
   output logic [31:0] s_addr_o,
   output logic [31:0] s_dat_o,
   output logic [3:0]  s_sel_o,
   input  logic        s_ack_i,
   input  logic        s_err_i,
   input  logic [31:0] s_dat_i,
   output logic [1:0]  grant_o,
   output logic        timeout_o
);

   typedef enum logic [1:0] {IDLE, BUSY_M0, BUSY_M1} state_t;

   localparam logic [TO_W-1:0] TO_VAL = TO_W'(TIMEOUT);
   localparam logic            TO_EN  = (TIMEOUT != 0);

   state_t          state_q, state_d;
   logic            last_owner_q;
   logic [TO_W-1:0] cnt_q;

   logic req0, req1, busy, sel_m1, mx_cyc, mx_stb, term, timeout_hit, xfer_end;

   assign req0   = m0_cyc_i & m0_stb_i;
   assign req1   = m1_cyc_i & m1_stb_i;
   assign busy   = (state_q != IDLE);
   assign sel_m1 = (state_q == BUSY_M1);
   assign mx_cyc = sel_m1 ? m1_cyc_i : m0_cyc_i;
   assign mx_stb = sel_m1 ? m1_stb_i : m0_stb_i;
   assign term   = s_ack_i | s_err_i;

   // A real slave answer in the deadline cycle wins over the forced timeout.
   assign timeout_hit = busy & TO_EN & (cnt_q == TO_VAL) & mx_cyc & ~term;
   assign xfer_end    = busy & (~mx_cyc | term | timeout_hit);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         last_owner_q <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state_q <= state_d;
         if (!busy)
            cnt_q <= '0;
         else if (!term && cnt_q != '1)
            cnt_q <= cnt_q + TO_W'(1);
         if (xfer_end)
            last_owner_q <= sel_m1;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (req0 && req1) begin
               if (ARB_MODE == 0)
                  state_d = BUSY_M1;
               else
                  state_d = last_owner_q ? BUSY_M0 : BUSY_M1;
            end else if (req1) begin
               state_d = BUSY_M1;
            end else if (req0) begin
               state_d = BUSY_M0;
            end
         end
         BUSY_M0, BUSY_M1: begin
            if (xfer_end)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign m0_dat_o = s_dat_i;
   assign m1_dat_o = s_dat_i;

   always_comb begin
      s_cyc_o   = 1'b0;
      s_stb_o   = 1'b0;
      s_we_o    = 1'b0;
      s_addr_o  = '0;
      s_dat_o   = '0;
      s_sel_o   = '0;
      m0_ack_o  = 1'b0;
      m0_err_o  = 1'b0;
      m1_ack_o  = 1'b0;
      m1_err_o  = 1'b0;
      grant_o   = {sel_m1, state_q == BUSY_M0};
      timeout_o = timeout_hit;
      if (busy) begin
         s_cyc_o  = mx_cyc & ~timeout_hit;
         s_stb_o  = mx_stb & ~timeout_hit;
         s_we_o   = sel_m1 ? m1_we_i   : m0_we_i;
         s_addr_o = sel_m1 ? m1_addr_i : m0_addr_i;
         s_dat_o  = sel_m1 ? m1_dat_i  : m0_dat_i;
         s_sel_o  = sel_m1 ? m1_sel_i  : m0_sel_i;
         // ERR dominates ACK; an aborted master gets no termination.
         if (sel_m1) begin
            m1_ack_o = mx_cyc & s_ack_i & ~s_err_i;
            m1_err_o = (mx_cyc & s_err_i) | timeout_hit;
         end else begin
            m0_ack_o = mx_cyc & s_ack_i & ~s_err_i;
            m0_err_o = (mx_cyc & s_err_i) | timeout_hit;
         end
      end
   end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// tb/tb_wb_bus_arbiter.sv - directed bench: instance 0 fixed priority, instance 1 round-robin, both TIMEOUT=4
module tb_wb_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
   logic [31:0] m0_addr, m0_wdat, m1_addr, m1_wdat;
   logic [3:0]  m0_sel, m1_sel;
   logic        s_ack, s_err;
   logic [31:0] s_rdat;

   logic [1:0]  m0_ack, m0_err, m1_ack, m1_err, s_cyc, s_stb, s_we, tmo;
   logic [31:0] m0_rdat [2];
   logic [31:0] m1_rdat [2];
   logic [31:0] s_addr [2];
   logic [31:0] s_wdat [2];
   logic [3:0]  s_sel [2];
   logic [1:0]  grant [2];

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      wb_bus_arbiter #(.ARB_MODE(g), .TIMEOUT(4), .TO_W(8)) dut (
         .clk_i(clk), .rst_ni(rst_ni),
         .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we),
         .m0_addr_i(m0_addr), .m0_dat_i(m0_wdat), .m0_sel_i(m0_sel),
         .m0_ack_o(m0_ack[g]), .m0_err_o(m0_err[g]), .m0_dat_o(m0_rdat[g]),
         .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we),
         .m1_addr_i(m1_addr), .m1_dat_i(m1_wdat), .m1_sel_i(m1_sel),
         .m1_ack_o(m1_ack[g]), .m1_err_o(m1_err[g]), .m1_dat_o(m1_rdat[g]),
         .s_cyc_o(s_cyc[g]), .s_stb_o(s_stb[g]), .s_we_o(s_we[g]),
         .s_addr_o(s_addr[g]), .s_dat_o(s_wdat[g]), .s_sel_o(s_sel[g]),
         .s_ack_i(s_ack), .s_err_i(s_err), .s_dat_i(s_rdat),
         .grant_o(grant[g]), .timeout_o(tmo[g])
      );
   end

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic m0_req(input logic [31:0] a);
      m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_addr = a; m0_sel = 4'hf;
   endtask

   task automatic m1_req(input logic [31:0] a);
      m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b0; m1_addr = a; m1_sel = 4'hf;
   endtask

   task automatic drop_all;
      m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
      s_ack = 1'b0; s_err = 1'b0;
   endtask

   task automatic test_reset;
      rst_ni = 1'b0;
      drop_all();
      m0_we = 0; m1_we = 0; m0_addr = 0; m1_addr = 0; m0_wdat = 0; m1_wdat = 0;
      m0_sel = 0; m1_sel = 0; s_rdat = 0;
      tick(); tick();
      m0_req(32'h0); m1_req(32'h0);
      tick();
      #1;
      checks++;
      if ({grant[0], grant[1]} !== 4'b0000) begin
         failures++; $display("FAIL reset_grant got=%b exp=0000", {grant[0], grant[1]});
      end
      checks++;
      if ({s_cyc, s_stb, tmo} !== 6'b0) begin
         failures++; $display("FAIL reset_ctrl got=%b exp=000000", {s_cyc, s_stb, tmo});
      end
      checks++;
      if ({m0_ack, m0_err, m1_ack, m1_err} !== 8'b0) begin
         failures++; $display("FAIL reset_term got=%b exp=00000000", {m0_ack, m0_err, m1_ack, m1_err});
      end
      drop_all();
      rst_ni = 1'b1;
      tick();
   endtask

   task automatic test_single_read;
      m0_req(32'h0000_0100);
      #1;
      checks++;
      if (grant[0] !== 2'b00) begin
         failures++; $display("FAIL t1_latency got=%b exp=00", grant[0]);
      end
      tick();
      checks++;
      if ({grant[0], s_cyc[0], s_addr[0], m0_ack[0]} !== {2'b01, 1'b1, 32'h100, 1'b0}) begin
         failures++; $display("FAIL t1_busy got=%b/%b/%h/%b exp=01/1/00000100/0", grant[0], s_cyc[0], s_addr[0], m0_ack[0]);
      end
      tick();
      tick();
      s_ack = 1'b1; s_rdat = 32'hDEAD_BEEF;
      #1;
      checks++;
      if ({m0_ack[0], m1_ack[0], m0_rdat[0]} !== {1'b1, 1'b0, 32'hDEAD_BEEF}) begin
         failures++; $display("FAIL t1_ack got=%b/%b/%h exp=1/0/deadbeef", m0_ack[0], m1_ack[0], m0_rdat[0]);
      end
      tick();
      drop_all();
      #1;
      checks++;
      if ({grant[0], m0_ack[0], s_cyc[0]} !== 4'b0000) begin
         failures++; $display("FAIL t1_idle got=%b exp=0000", {grant[0], m0_ack[0], s_cyc[0]});
      end
   endtask

   task automatic test_fixed_priority;
      m0_req(32'h200); m1_req(32'h300);
      tick();
      checks++;
      if ({grant[0], s_addr[0]} !== {2'b10, 32'h300}) begin
         failures++; $display("FAIL t2_first got=%b/%h exp=10/00000300", grant[0], s_addr[0]);
      end
      s_ack = 1'b1;
      #1;
      checks++;
      if ({m1_ack[0], m0_ack[0]} !== 2'b10) begin
         failures++; $display("FAIL t2_ack_route got=%b exp=10", {m1_ack[0], m0_ack[0]});
      end
      tick();
      s_ack = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
      #1;
      checks++;
      if (grant[0] !== 2'b00) begin
         failures++; $display("FAIL t2_gap got=%b exp=00", grant[0]);
      end
      tick();
      checks++;
      if ({grant[0], s_addr[0]} !== {2'b01, 32'h200}) begin
         failures++; $display("FAIL t2_second got=%b/%h exp=01/00000200", grant[0], s_addr[0]);
      end
      s_ack = 1'b1;
      #1;
      checks++;
      if ({m1_ack[0], m0_ack[0]} !== 2'b01) begin
         failures++; $display("FAIL t2_ack_m0 got=%b exp=01", {m1_ack[0], m0_ack[0]});
      end
      tick();
      drop_all();
      tick();
   endtask

   task automatic test_round_robin;
      m1_req(32'h400);
      tick();
      s_ack = 1'b1;
      tick();
      drop_all();
      tick();
      m0_req(32'h500); m1_req(32'h600);
      tick();
      checks++;
      if ({grant[0], grant[1]} !== 4'b1001) begin
         failures++; $display("FAIL t2_rr_grant got=%b exp=1001", {grant[0], grant[1]});
      end
      s_ack = 1'b1;
      #1;
      checks++;
      if ({m1_ack[0], m0_ack[0], m1_ack[1], m0_ack[1]} !== 4'b1001) begin
         failures++; $display("FAIL t2_rr_ack got=%b exp=1001", {m1_ack[0], m0_ack[0], m1_ack[1], m0_ack[1]});
      end
      tick();
      drop_all();
      tick();
      m0_req(32'h500); m1_req(32'h600);
      tick();
      checks++;
      if ({grant[0], grant[1]} !== 4'b1010) begin
         failures++; $display("FAIL t2_rr_alt got=%b exp=1010", {grant[0], grant[1]});
      end
      s_ack = 1'b1;
      tick();
      drop_all();
      tick();
   endtask

   task automatic test_ack_err;
      m1_req(32'h10); m1_we = 1'b1; m1_sel = 4'b0100; m1_wdat = 32'h1234_5678;
      tick();
      checks++;
      if ({grant[0], s_we[0], s_sel[0], s_addr[0], s_wdat[0]} !== {2'b10, 1'b1, 4'b0100, 32'h10, 32'h1234_5678}) begin
         failures++; $display("FAIL t3_mux got=%b/%b/%b/%h/%h exp=10/1/0100/00000010/12345678", grant[0], s_we[0], s_sel[0], s_addr[0], s_wdat[0]);
      end
      s_ack = 1'b1; s_err = 1'b1;
      #1;
      checks++;
      if ({m1_err[0], m1_ack[0], m0_err[0], m0_ack[0], tmo[0]} !== 5'b10000) begin
         failures++; $display("FAIL t3_err_wins got=%b exp=10000", {m1_err[0], m1_ack[0], m0_err[0], m0_ack[0], tmo[0]});
      end
      tick();
      drop_all(); m1_we = 1'b0;
      #1;
      checks++;
      if (grant[0] !== 2'b00) begin
         failures++; $display("FAIL t3_idle got=%b exp=00", grant[0]);
      end
      tick();
   endtask

   task automatic test_timeout;
      logic e;
      m1_req(32'h20);
      tick();
      for (int i = 1; i <= 5; i++) begin
         e = (i == 5);
         #1;
         checks++;
         if ({tmo[0], m1_err[0], tmo[1]} !== {e, e, e}) begin
            failures++; $display("FAIL t4_pulse cycle=%0d got=%b exp=%b", i, {tmo[0], m1_err[0], tmo[1]}, {e, e, e});
         end
         checks++;
         if ({s_cyc[0], s_stb[0]} !== {!e, !e}) begin
            failures++; $display("FAIL t4_cyc cycle=%0d got=%b exp=%b", i, {s_cyc[0], s_stb[0]}, {!e, !e});
         end
         if (i < 5) tick();
      end
      tick();
      checks++;
      if ({grant[0], tmo[0], m1_err[0]} !== 4'b0000) begin
         failures++; $display("FAIL t4_after got=%b exp=0000", {grant[0], tmo[0], m1_err[0]});
      end
      drop_all();
      tick();
   endtask

   task automatic test_master_abort;
      m0_req(32'h30);
      tick();
      checks++;
      if ({grant[0], s_cyc[0]} !== 3'b011) begin
         failures++; $display("FAIL t5_busy got=%b exp=011", {grant[0], s_cyc[0]});
      end
      tick();
      m0_cyc = 1'b0; m0_stb = 1'b0; m1_req(32'h40); s_ack = 1'b1;
      #1;
      checks++;
      if ({grant[0], s_cyc[0], m0_ack[0], m0_err[0], m1_ack[0]} !== 6'b010000) begin
         failures++; $display("FAIL t5_abort got=%b exp=010000", {grant[0], s_cyc[0], m0_ack[0], m0_err[0], m1_ack[0]});
      end
      tick();
      s_ack = 1'b0;
      #1;
      checks++;
      if ({grant[0], s_cyc[0]} !== 3'b000) begin
         failures++; $display("FAIL t5_idle got=%b exp=000", {grant[0], s_cyc[0]});
      end
      tick();
      checks++;
      if ({grant[0], s_addr[0]} !== {2'b10, 32'h40}) begin
         failures++; $display("FAIL t5_next got=%b/%h exp=10/00000040", grant[0], s_addr[0]);
      end
      s_ack = 1'b1;
      tick();
      drop_all();
      tick();
   endtask

   task automatic test_reset_mid_transfer;
      m1_req(32'h50);
      tick();
      checks++;
      if ({grant[0], s_cyc[0]} !== 3'b101) begin
         failures++; $display("FAIL t6_busy got=%b exp=101", {grant[0], s_cyc[0]});
      end
      rst_ni = 1'b0;
      tick();
      checks++;
      if ({grant[0], grant[1], s_cyc} !== 6'b0) begin
         failures++; $display("FAIL t6_reset got=%b exp=000000", {grant[0], grant[1], s_cyc});
      end
      rst_ni = 1'b1;
      m1_cyc = 1'b0; m1_stb = 1'b0; s_ack = 1'b1;
      #1;
      checks++;
      if ({m0_ack, m0_err, m1_ack, m1_err} !== 8'b0) begin
         failures++; $display("FAIL t6_late_ack got=%b exp=00000000", {m0_ack, m0_err, m1_ack, m1_err});
      end
      tick();
      s_ack = 1'b0;
      #1;
      checks++;
      if ({grant[0], grant[1]} !== 4'b0000) begin
         failures++; $display("FAIL t6_idle got=%b exp=0000", {grant[0], grant[1]});
      end
      m0_req(32'h60); m1_req(32'h70);
      tick();
      checks++;
      if ({grant[0], grant[1]} !== 4'b1010) begin
         failures++; $display("FAIL t6_last_owner got=%b exp=1010", {grant[0], grant[1]});
      end
      s_ack = 1'b1;
      tick();
      drop_all();
      tick();
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_fixed_priority();
      test_round_robin();
      test_ack_err();
      test_timeout();
      test_master_abort();
      test_reset_mid_transfer();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=expired exp=finished");
      $fatal(1, "watchdog");
   end

endmodule
